// File: rtl/paging_request_arbiter.sv
// Arbitrates the shared page-walk unit between the data and code requesters,
// with a one-entry translation cache per requester and paging-off bypass.
module paging_request_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        i_paging_enable,
    input  logic [31:0] i_page_directory_base,
    input  logic        i_flush,
    input  logic        i_data_valid,
    input  logic [31:0] i_data_linear_address,
    output logic        o_data_ready,
    output logic [31:0] o_data_physical_address,
    input  logic        i_code_valid,
    input  logic [31:0] i_code_linear_address,
    output logic        o_code_ready,
    output logic [31:0] o_code_physical_address,
    output logic        o_walk_valid,
    output logic [31:0] o_walk_linear_address,
    output logic [31:0] o_walk_page_directory_base,
    input  logic        i_walk_ready,
    input  logic [31:0] i_walk_physical_address
);

    localparam int CW = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {IDLE, WALK_ISSUE, WALK_WAIT, RESPOND} state_t;

    state_t        state_reg, state_next;
    logic          grant_code_reg, grant_code_next;
    logic [31:0]   lin_reg, lin_next;
    logic [31:0]   cr3_reg, cr3_next;
    logic [CW-1:0] starve_reg, starve_next;
    logic          drop_fill_reg, drop_fill_next;
    logic          resp_en;
    logic [31:0]   resp_phys;
    logic          fill_en;

    // Index 0 is the data requester, index 1 the code requester.
    logic [1:0]    entry_valid_reg;
    logic [19:0]   entry_tag_reg   [2];
    logic [19:0]   entry_frame_reg [2];
    logic [31:0]   phys_reg        [2];
    logic [31:0]   req_lin         [2];
    logic [1:0]    hit;
    logic [1:0]    ready;

    logic unused_low_bits;
    assign unused_low_bits = ^{i_walk_physical_address[11:0], i_page_directory_base[11:0]};

    assign req_lin[0] = i_data_linear_address;
    assign req_lin[1] = i_code_linear_address;

    // A same-cycle flush makes the lookup see both entries as invalid.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_entry
            assign hit[gi]   = entry_valid_reg[gi] && !i_flush &&
                               (entry_tag_reg[gi] == req_lin[gi][31:12]);
            assign ready[gi] = (state_reg == RESPOND) && (grant_code_reg == 1'(gi));
        end
    endgenerate

    assign o_data_ready               = ready[0];
    assign o_code_ready               = ready[1];
    assign o_data_physical_address    = phys_reg[0];
    assign o_code_physical_address    = phys_reg[1];
    assign o_walk_valid               = (state_reg == WALK_ISSUE);
    assign o_walk_linear_address      = lin_reg;
    assign o_walk_page_directory_base = cr3_reg;

    always_comb begin
        state_next      = state_reg;
        grant_code_next = grant_code_reg;
        lin_next        = lin_reg;
        cr3_next        = cr3_reg;
        starve_next     = starve_reg;
        drop_fill_next  = drop_fill_reg;
        resp_en         = 1'b0;
        resp_phys       = 32'h0;
        fill_en         = 1'b0;
        case (state_reg)
            IDLE: begin
                if (i_data_valid || i_code_valid) begin
                    grant_code_next = i_code_valid &&
                                      (!i_data_valid || starve_reg == CW'(STARVE_LIMIT));
                    lin_next        = grant_code_next ? i_code_linear_address : i_data_linear_address;
                    cr3_next        = {i_page_directory_base[31:12], 12'h000};
                    if (grant_code_next)
                        starve_next = '0;
                    else if (i_code_valid && starve_reg != CW'(STARVE_LIMIT))
                        starve_next = starve_reg + 1'b1;
                    if (!i_paging_enable) begin
                        state_next = RESPOND;
                        resp_en    = 1'b1;
                        resp_phys  = lin_next;
                    end else if (hit[grant_code_next]) begin
                        state_next = RESPOND;
                        resp_en    = 1'b1;
                        resp_phys  = {entry_frame_reg[grant_code_next], lin_next[11:0]};
                    end else begin
                        state_next = WALK_ISSUE;
                    end
                end
            end
            WALK_ISSUE: begin
                state_next = WALK_WAIT;
                if (i_flush)
                    drop_fill_next = 1'b1;
            end
            WALK_WAIT: begin
                if (i_flush)
                    drop_fill_next = 1'b1;
                if (i_walk_ready) begin
                    state_next = RESPOND;
                    resp_en    = 1'b1;
                    resp_phys  = {i_walk_physical_address[31:12], lin_reg[11:0]};
                    fill_en    = !drop_fill_reg && !i_flush;
                end
            end
            RESPOND: begin
                state_next     = IDLE;
                drop_fill_next = 1'b0;
            end
            default: state_next = IDLE;
        endcase
        if (!i_code_valid)
            starve_next = '0;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg       <= IDLE;
            grant_code_reg  <= 1'b0;
            lin_reg         <= 32'h0;
            cr3_reg         <= 32'h0;
            starve_reg      <= '0;
            drop_fill_reg   <= 1'b0;
            entry_valid_reg <= 2'b00;
            for (int i = 0; i < 2; i++) begin
                entry_tag_reg[i]   <= 20'h0;
                entry_frame_reg[i] <= 20'h0;
                phys_reg[i]        <= 32'h0;
            end
        end else begin
            state_reg      <= state_next;
            grant_code_reg <= grant_code_next;
            lin_reg        <= lin_next;
            cr3_reg        <= cr3_next;
            starve_reg     <= starve_next;
            drop_fill_reg  <= drop_fill_next;
            if (resp_en)
                phys_reg[grant_code_next] <= resp_phys;
            // Flush wins over a fill landing in the same cycle.
            if (i_flush) begin
                entry_valid_reg <= 2'b00;
            end else if (fill_en) begin
                entry_valid_reg[grant_code_reg] <= 1'b1;
                entry_tag_reg[grant_code_reg]   <= lin_reg[31:12];
                entry_frame_reg[grant_code_reg] <= i_walk_physical_address[31:12];
            end
        end
    end

endmodule

// File: tb/tb_paging_request_arbiter.sv
// Directed bench for paging_request_arbiter: bypass, walk/hit, starvation
// ordering, flush interactions and asynchronous reset.
module tb_paging_request_arbiter;

    logic        clock;
    logic        reset;
    logic        i_paging_enable;
    logic [31:0] i_page_directory_base;
    logic        i_flush;
    logic        i_data_valid;
    logic [31:0] i_data_linear_address;
    logic        o_data_ready;
    logic [31:0] o_data_physical_address;
    logic        i_code_valid;
    logic [31:0] i_code_linear_address;
    logic        o_code_ready;
    logic [31:0] o_code_physical_address;
    logic        o_walk_valid;
    logic [31:0] o_walk_linear_address;
    logic [31:0] o_walk_page_directory_base;
    logic        i_walk_ready;
    logic [31:0] i_walk_physical_address;

    int          n_total = 0;
    int          n_pass  = 0;
    int          walk_cnt = 0;
    int          both_cnt = 0;
    bit          order_q[$];
    bit          walker_on = 1;
    int          flush_mode = 0;
    logic [31:0] walk_frame = 32'h0;
    logic [31:0] last_walk_addr = 32'h0;
    logic [31:0] last_walk_base = 32'h0;

    paging_request_arbiter #(.STARVE_LIMIT(4)) dut (
        .clock                      (clock),
        .reset                      (reset),
        .i_paging_enable            (i_paging_enable),
        .i_page_directory_base      (i_page_directory_base),
        .i_flush                    (i_flush),
        .i_data_valid               (i_data_valid),
        .i_data_linear_address      (i_data_linear_address),
        .o_data_ready               (o_data_ready),
        .o_data_physical_address    (o_data_physical_address),
        .i_code_valid               (i_code_valid),
        .i_code_linear_address      (i_code_linear_address),
        .o_code_ready               (o_code_ready),
        .o_code_physical_address    (o_code_physical_address),
        .o_walk_valid               (o_walk_valid),
        .o_walk_linear_address      (o_walk_linear_address),
        .o_walk_page_directory_base (o_walk_page_directory_base),
        .i_walk_ready               (i_walk_ready),
        .i_walk_physical_address    (i_walk_physical_address)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
            $display("ok   %s: got %h", tag, got);
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    always @(negedge clock) begin
        if (o_walk_valid) walk_cnt++;
        if (o_data_ready && o_code_ready) both_cnt++;
        if (o_data_ready) order_q.push_back(1'b0);
        if (o_code_ready) order_q.push_back(1'b1);
    end

    // Walker model: answers 3 clocks after the walk pulse; low frame bits are junk.
    initial begin
        i_walk_ready            = 1'b0;
        i_walk_physical_address = 32'h0;
        i_flush                 = 1'b0;
        forever begin
            @(negedge clock);
            if (o_walk_valid && walker_on) begin
                last_walk_addr = o_walk_linear_address;
                last_walk_base = o_walk_page_directory_base;
                @(negedge clock);
                if (flush_mode == 1) i_flush = 1'b1;
                @(negedge clock);
                i_flush = 1'b0;
                @(negedge clock);
                i_walk_ready            = 1'b1;
                i_walk_physical_address = walk_frame | 32'h0000_05A5;
                if (flush_mode == 2) i_flush = 1'b1;
                @(negedge clock);
                i_walk_ready = 1'b0;
                i_flush      = 1'b0;
            end
        end
    end

    task automatic req(input bit is_code, input logic [31:0] addr, input logic [31:0] exp_phys,
                       input int exp_lat, input string tag);
        bit seen = 0;
        int lat  = 0;
        if (is_code) begin
            i_code_valid = 1'b1;
            i_code_linear_address = addr;
        end else begin
            i_data_valid = 1'b1;
            i_data_linear_address = addr;
        end
        for (int c = 1; c <= 40 && !seen; c++) begin
            @(negedge clock);
            if ((is_code && o_code_ready) || (!is_code && o_data_ready)) begin
                seen = 1;
                lat  = c;
            end
        end
        check({tag, "_ready"}, 32'(seen), 32'd1);
        check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        check({tag, "_phys"}, is_code ? o_code_physical_address : o_data_physical_address, exp_phys);
        i_code_valid = 1'b0;
        i_data_valid = 1'b0;
        @(negedge clock);
    endtask

    initial begin
        int w0;
        bit seen;
        logic [9:0] order_bits;
        reset                 = 1'b1;
        i_paging_enable       = 1'b0;
        i_page_directory_base = 32'h0010_0000;
        i_data_valid          = 1'b0;
        i_data_linear_address = 32'h0;
        i_code_valid          = 1'b0;
        i_code_linear_address = 32'h0;
        repeat (3) @(negedge clock);
        check("rst_data_ready", 32'(o_data_ready), 32'd0);
        check("rst_code_ready", 32'(o_code_ready), 32'd0);
        check("rst_walk_valid", 32'(o_walk_valid), 32'd0);
        check("rst_walk_addr", o_walk_linear_address, 32'h0);
        check("rst_data_phys", o_data_physical_address, 32'h0);
        reset = 1'b0;
        @(negedge clock);

        // Paging off: bypass.
        req(0, 32'h1234_5678, 32'h1234_5678, 1, "t1_bypass");
        check("t1_no_walk", 32'(walk_cnt), 32'd0);

        // Paging on: code miss walks, then hits.
        i_paging_enable = 1'b1;
        walk_frame = 32'h0009_8000;
        req(1, 32'h0040_1ABC, 32'h0009_8ABC, 5, "t2_code_miss");
        check("t2_walk_cnt", 32'(walk_cnt), 32'd1);
        check("t2_walk_addr", last_walk_addr, 32'h0040_1ABC);
        check("t2_walk_base", last_walk_base, 32'h0010_0000);
        req(1, 32'h0040_1FF0, 32'h0009_8FF0, 1, "t2_code_hit");
        check("t2_hit_no_walk", 32'(walk_cnt), 32'd1);
        walk_frame = 32'h0012_3000;
        req(0, 32'h0080_0010, 32'h0012_3010, 5, "t2_data_miss");

        // Both requesters held valid with hits: starvation forcing.
        order_q.delete();
        w0 = walk_cnt;
        i_data_linear_address = 32'h0080_0444;
        i_code_linear_address = 32'h0040_1222;
        i_data_valid = 1'b1;
        i_code_valid = 1'b1;
        repeat (20) @(negedge clock);
        i_data_valid = 1'b0;
        i_code_valid = 1'b0;
        @(negedge clock);
        check("t3_grant_count", 32'(order_q.size()), 32'd10);
        order_bits = '0;
        for (int i = 0; i < 10 && i < order_q.size(); i++) order_bits[i] = order_q[i];
        check("t3_grant_order", 32'(order_bits), 32'(10'b10000_10000));
        check("t3_no_dual_ready", 32'(both_cnt), 32'd0);
        check("t3_no_walk", 32'(walk_cnt - w0), 32'd0);
        check("t3_data_phys", o_data_physical_address, 32'h0012_3444);
        check("t3_code_phys", o_code_physical_address, 32'h0009_8222);

        // Flush during WALK_WAIT: result returned, fill dropped.
        w0 = walk_cnt;
        walk_frame = 32'h0045_6000;
        flush_mode = 1;
        req(0, 32'h00C0_0123, 32'h0045_6123, 5, "t4_flush_walk");
        flush_mode = 0;
        req(0, 32'h00C0_0123, 32'h0045_6123, 5, "t4_rewalk");
        check("t4_walk_cnt", 32'(walk_cnt - w0), 32'd2);
        req(0, 32'h00C0_0777, 32'h0045_6777, 1, "t4_hit_after");

        // Flush coincident with walk completion.
        w0 = walk_cnt;
        walk_frame = 32'h0011_1000;
        flush_mode = 2;
        req(1, 32'h0070_0004, 32'h0011_1004, 5, "t5_flush_ready");
        flush_mode = 0;
        req(1, 32'h0070_0008, 32'h0011_1008, 5, "t5_still_miss");
        check("t5_walk_cnt", 32'(walk_cnt - w0), 32'd2);

        // Reset in WALK_WAIT clears outputs at once and empties the cache.
        walk_frame = 32'h00AB_C000;
        req(0, 32'h00D0_0123, 32'h00AB_C123, 5, "t6_fill");
        req(0, 32'h00D0_0456, 32'h00AB_C456, 1, "t6_hit");
        walker_on = 0;
        i_code_valid = 1'b1;
        i_code_linear_address = 32'h00E0_0000;
        seen = 0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clock);
            if (o_walk_valid) seen = 1;
        end
        check("t6_walk_started", 32'(seen), 32'd1);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        #1;
        check("t6_async_walk_addr", o_walk_linear_address, 32'h0);
        check("t6_async_walk_base", o_walk_page_directory_base, 32'h0);
        check("t6_async_data_phys", o_data_physical_address, 32'h0);
        check("t6_async_walk_valid", 32'(o_walk_valid), 32'd0);
        i_code_valid = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        walker_on = 1;
        @(negedge clock);
        w0 = walk_cnt;
        walk_frame = 32'h00CD_E000;
        req(0, 32'h00D0_0123, 32'h00CD_E123, 5, "t6_miss_after_reset");
        check("t6_walk_cnt", 32'(walk_cnt - w0), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
